axi_stream_header_arbiter: RTL and testbench
============================================

Name: axi_stream_header_arbiter

Overview:
- Shares the single header-insert port of the AXI-Stream header inserter between NUM_SRC independent header requesters.
- Grants one requester per packet, round-robin, and forwards its header through a registered slice.
- Holds the grant until the inserter's output stream completes the packet (last_out beat handshaken), then re-arbitrates.
- Sits directly in front of the inserter's valid_insert/data_insert/keep_insert/byte_insert_cnt/ready_insert port and taps its output handshake.

Parameters:
- NUM_SRC, 4, number of header requesters (>=1)
- DATA_WD, 32, header data width in bits
- DATA_BYTE_WD, DATA_WD/8, keep width
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), byte-count width
- SRC_WD, (NUM_SRC>1 ? $clog2(NUM_SRC) : 1), grant index width

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- src_enable  input  NUM_SRC  per-source arbitration enable mask
- src_valid  input  NUM_SRC  per-source header valid
- src_data  input  NUM_SRC*DATA_WD  headers; source i at [i*DATA_WD +: DATA_WD]
- src_keep  input  NUM_SRC*DATA_BYTE_WD  per-source header keep
- src_byte_cnt  input  NUM_SRC*BYTE_CNT_WD  per-source byte_insert_cnt
- src_ready  output  NUM_SRC  per-source accept (one-hot or zero)
- valid_insert  output  1  header valid to inserter
- data_insert  output  DATA_WD  header to inserter
- keep_insert  output  DATA_BYTE_WD  keep to inserter
- byte_insert_cnt  output  BYTE_CNT_WD  byte count to inserter
- ready_insert  input  1  inserter header ready
- valid_out  input  1  tap of inserter output valid
- ready_out  input  1  tap of inserter output ready
- last_out  input  1  tap of inserter output last
- grant_id  output  SRC_WD  index of current/last granted source
- busy  output  1  high in OFFER or PACKET
- pkt_done_cnt  output  16  completed-packet counter, wraps

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; rr_ptr=0; grant_id=0.
  - valid_insert=0; data_insert/keep_insert/byte_insert_cnt=0; pkt_done_cnt=0.
  - src_ready=0; busy=0.
- Reset mid-packet aborts immediately: the header in flight is dropped, and no src_ready is issued in the reset cycle.
- Arbitration: eligible set req = src_valid & src_enable. The winner is the first set bit of req, searching from index rr_ptr upward and wrapping NUM_SRC-1 -> 0. Purely combinational on the current cycle.
- State IDLE:
  - src_ready[winner]=1 (one-hot) when req!=0, else src_ready=0.
  - On a handshake of the winner, capture its data/keep/byte_cnt into the output registers and set grant_id=winner.
  - Same edge: valid_insert<=1, state->OFFER.
  - Latency: source handshake at cycle T gives valid_insert high at T+1.
- State OFFER:
  - valid_insert=1; data/keep/cnt held stable (AXI rule); src_ready=0.
  - On valid_insert&&ready_insert: valid_insert<=0, state->PACKET.
- State PACKET:
  - src_ready=0, valid_insert=0.
  - On valid_out&&ready_out&&last_out: pkt_done_cnt+=1 (wraps 0xFFFF->0), rr_ptr<=(grant_id+1) mod NUM_SRC, state->IDLE.
- Re-arbitration: minimum one idle cycle between packets. Next src_ready is no earlier than the cycle after the last_out handshake.
- last_out handshakes seen in IDLE or OFFER are ignored: no count, no state change.
- Clearing src_enable bits mid-packet does not abort the grant; the mask applies only at the next arbitration.
- src_valid dropping before a handshake: no capture, re-evaluated next cycle.
- NUM_SRC=1: rr_ptr stays 0; behaviour is a plain register slice with packet lock.
- busy = (state!=IDLE).

Test Plan:
- Reset, then src_valid=4'b0010 with src_data[1]=0xAABBCCDD, keep=4'hF, cnt=3 → src_ready=4'b0010 at T; valid_insert=1, data_insert=0xAABBCCDD, grant_id=1 at T+1.
- All four valid, ready_insert=1, one 2-beat packet per grant → grant order 0,1,2,3,0; pkt_done_cnt=5; never more than one src_ready bit high.
- ready_insert held 0 for 5 cycles in OFFER → valid_insert stays 1 and data_insert stays stable; no src_ready pulses.
- After granting source 2, last_out asserted with ready_out=0 for 3 cycles → stays PACKET; on ready_out=1 → IDLE next cycle, rr_ptr=3.
- src_enable=4'b1011 with all sources valid → source 2 never granted; clearing bit 0 mid-packet leaves the current grant intact until last_out.
- Reset asserted in PACKET → all outputs 0 asynchronously; after release, arbitration restarts from source 0 and pkt_done_cnt=0.

Source files
------------

// File: rtl/axi_stream_header_arbiter.sv
// axi_stream_header_arbiter: round-robin sharing of one header-insert port, grant held until the packet's last beat.
module axi_stream_header_arbiter #(
   parameter int NUM_SRC      = 4,
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
   parameter int SRC_WD       = (NUM_SRC > 1 ? $clog2(NUM_SRC) : 1)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_SRC-1:0]              src_enable,
   input  logic [NUM_SRC-1:0]              src_valid,
   input  logic [NUM_SRC*DATA_WD-1:0]      src_data,
   input  logic [NUM_SRC*DATA_BYTE_WD-1:0] src_keep,
   input  logic [NUM_SRC*BYTE_CNT_WD-1:0]  src_byte_cnt,
   output logic [NUM_SRC-1:0]              src_ready,
   output logic                            valid_insert,
   output logic [DATA_WD-1:0]              data_insert,
   output logic [DATA_BYTE_WD-1:0]         keep_insert,
   output logic [BYTE_CNT_WD-1:0]          byte_insert_cnt,
   input  logic                            ready_insert,
   input  logic                            valid_out,
   input  logic                            ready_out,
   input  logic                            last_out,
   output logic [SRC_WD-1:0]               grant_id,
   output logic                            busy,
   output logic [15:0]                     pkt_done_cnt
);
   typedef enum logic [1:0] {IDLE, OFFER, PACKET} state_t;
   state_t state;
   logic [SRC_WD-1:0] rr_ptr, winner;
   logic [NUM_SRC-1:0] req;
   int k;
   assign req = src_valid & src_enable;
   // scan downward so the lowest offset from rr_ptr is written last and wins
   always_comb begin
      winner = rr_ptr;
      k = 0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         k = int'(rr_ptr) + i;
         k = (k >= NUM_SRC) ? k - NUM_SRC : k;
         if (req[SRC_WD'(k)]) winner = SRC_WD'(k);
      end
   end
   assign src_ready = (rst_n && state == IDLE && |req) ? NUM_SRC'(1) << winner : '0;
   assign busy = state != IDLE;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         rr_ptr          <= '0;
         grant_id        <= '0;
         valid_insert    <= 1'b0;
         data_insert     <= '0;
         keep_insert     <= '0;
         byte_insert_cnt <= '0;
         pkt_done_cnt    <= '0;
      end else begin
         case (state)
            IDLE: if (|req) begin
               data_insert     <= src_data[int'(winner)*DATA_WD +: DATA_WD];
               keep_insert     <= src_keep[int'(winner)*DATA_BYTE_WD +: DATA_BYTE_WD];
               byte_insert_cnt <= src_byte_cnt[int'(winner)*BYTE_CNT_WD +: BYTE_CNT_WD];
               grant_id        <= winner;
               valid_insert    <= 1'b1;
               state           <= OFFER;
            end
            OFFER: if (ready_insert) begin
               valid_insert <= 1'b0;
               state        <= PACKET;
            end
            PACKET: if (valid_out && ready_out && last_out) begin
               pkt_done_cnt <= pkt_done_cnt + 16'd1;
               rr_ptr       <= (grant_id == SRC_WD'(NUM_SRC - 1)) ? '0 : grant_id + 1'b1;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_stream_header_arbiter.sv
// tb_axi_stream_header_arbiter: randomized and directed scoreboard bench against a packet-level reference model.
module tb_axi_stream_header_arbiter;
   localparam int N = 4, DW = 32, BW = 4, CW = 2, SW = 2;
   logic clk = 0, rst_n = 0;
   logic [N-1:0] src_enable = '1, src_valid = '0, src_ready;
   logic [N*DW-1:0] src_data = '0;
   logic [N*BW-1:0] src_keep = '0;
   logic [N*CW-1:0] src_byte_cnt = '0;
   logic valid_insert, ready_insert = 0, valid_out = 0, ready_out = 0, last_out = 0, busy;
   logic [DW-1:0] data_insert;
   logic [BW-1:0] keep_insert;
   logic [CW-1:0] byte_insert_cnt;
   logic [SW-1:0] grant_id;
   logic [15:0] pkt_done_cnt;

   axi_stream_header_arbiter #(.NUM_SRC(N), .DATA_WD(DW)) dut (
      .clk(clk), .rst_n(rst_n), .src_enable(src_enable), .src_valid(src_valid),
      .src_data(src_data), .src_keep(src_keep), .src_byte_cnt(src_byte_cnt),
      .src_ready(src_ready), .valid_insert(valid_insert), .data_insert(data_insert),
      .keep_insert(keep_insert), .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
      .valid_out(valid_out), .ready_out(ready_out), .last_out(last_out),
      .grant_id(grant_id), .busy(busy), .pkt_done_cnt(pkt_done_cnt));

   always #5 clk = ~clk;

   typedef struct {int id; logic [DW-1:0] d; logic [BW-1:0] k; logic [CW-1:0] c;} hdr_t;
   hdr_t q[$];
   int glog[$];
   bit log_en = 0;
   int checks = 0, failures = 0;
   // packet-level model: phase 0 = waiting for a grant, 1 = header offered, 2 = packet streaming
   int m_ph = 0, m_rr = 0, m_gid = 0, m_done = 0;
   logic [N-1:0] exp_ready = '0;
   logic exp_vi = 0, exp_busy = 0;
   int exp_gid = 0, exp_cnt = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(logic [N-1:0] r, int rr);
      for (int i = 0; i < N; i++) if (r[(rr + i) % N]) return (rr + i) % N;
      return -1;
   endfunction

   task automatic tick();
      logic [N-1:0] r;
      int w;
      r = src_valid & src_enable;
      exp_ready = '0;
      exp_vi = (m_ph == 1);
      exp_busy = (m_ph != 0);
      exp_gid = m_gid;
      exp_cnt = m_done;
      if (!rst_n) begin
         m_ph = 0; m_rr = 0; m_gid = 0; m_done = 0;
         exp_vi = 0; exp_busy = 0; exp_gid = 0; exp_cnt = 0;
         q.delete();
      end else if (m_ph == 0) begin
         if (r != 0) begin
            hdr_t h;
            w = pick(r, m_rr);
            exp_ready = N'(1) << w;
            h.id = w; h.d = src_data[w*DW +: DW]; h.k = src_keep[w*BW +: BW]; h.c = src_byte_cnt[w*CW +: CW];
            q.push_back(h);
            m_gid = w;
            m_ph = 1;
         end
      end else if (m_ph == 1) begin
         if (ready_insert) m_ph = 2;
      end else if (valid_out && ready_out && last_out) begin
         m_done = (m_done + 1) & 16'hFFFF;
         m_rr = (m_gid + 1) % N;
         m_ph = 0;
      end
      @(posedge clk); #1;
   endtask

   task automatic rnd_data();
      src_data = {$urandom, $urandom, $urandom, $urandom};
      src_keep = 16'($urandom);
      src_byte_cnt = 8'($urandom);
   endtask

   always @(negedge clk) begin
      chk("src_ready", 32'(src_ready), 32'(exp_ready));
      chk("valid_insert", 32'(valid_insert), 32'(exp_vi));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("grant_id", 32'(grant_id), 32'(exp_gid));
      chk("pkt_done_cnt", 32'(pkt_done_cnt), 32'(exp_cnt));
      if (valid_insert) begin
         if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL hdr_unexpected actual=valid_insert expected=no_header t=%0t", $time);
         end else begin
            chk("hdr_data", data_insert, q[0].d);
            chk("hdr_keep", 32'(keep_insert), 32'(q[0].k));
            chk("hdr_cnt", 32'(byte_insert_cnt), 32'(q[0].c));
            chk("hdr_id", 32'(grant_id), 32'(q[0].id));
            if (ready_insert) begin
               if (log_en) glog.push_back(int'(grant_id));
               void'(q.pop_front());
            end
         end
      end
   end

   task automatic finish_pkt();
      valid_out = 1; ready_out = 1; last_out = 1;
      tick();
      valid_out = 0; ready_out = 0; last_out = 0;
   endtask

   initial begin
      int n, g2;
      repeat (3) tick();
      chk("rst_cnt", 32'(pkt_done_cnt), 0);
      rst_n = 1;
      // round robin: all sources valid, 2-beat packets
      src_valid = '1; ready_insert = 1; valid_out = 1; ready_out = 1;
      log_en = 1; glog.delete(); n = 0;
      while (m_done < 5 && n < 200) begin
         rnd_data();
         last_out = n[0];
         tick();
         n++;
      end
      src_valid = '0; ready_insert = 0; valid_out = 0; ready_out = 0; last_out = 0; log_en = 0;
      tick();
      chk("rr_pkt_cnt", 32'(pkt_done_cnt), 5);
      chk("rr_grants", 32'(glog.size()), 5);
      for (int i = 0; i < 5 && i < glog.size(); i++) chk("rr_order", 32'(glog[i]), 32'(i % N));
      // single source 1 header, held in OFFER for 5 cycles
      rnd_data();
      src_valid = 4'b0010; src_data[DW +: DW] = 32'hAABBCCDD; src_keep[BW +: BW] = 4'hF; src_byte_cnt[CW +: CW] = 2'd3;
      #1 chk("t_ready", 32'(src_ready), 32'b0010);
      tick();
      src_valid = '0;
      chk("t1_valid", 32'(valid_insert), 1);
      chk("t1_data", data_insert, 32'hAABBCCDD);
      chk("t1_gid", 32'(grant_id), 1);
      src_valid = '1;
      repeat (5) begin rnd_data(); tick(); end
      chk("offer_hold", data_insert, 32'hAABBCCDD);
      ready_insert = 1; tick(); ready_insert = 0;
      #1 chk("next_rr", 32'(src_ready), 32'b0000);
      src_valid = '0;
      finish_pkt();
      // source 2 now first in line; last_out stalled by ready_out
      src_valid = '1;
      #1 chk("win2", 32'(src_ready), 32'b0100);
      tick();
      src_valid = '0; ready_insert = 1; tick(); ready_insert = 0;
      valid_out = 1; last_out = 1; ready_out = 0;
      repeat (3) tick();
      chk("stall_busy", 32'(busy), 1);
      ready_out = 1; tick(); valid_out = 0; last_out = 0; ready_out = 0;
      chk("stall_idle", 32'(busy), 0);
      src_valid = '1;
      #1 chk("win3", 32'(src_ready), 32'b1000);
      tick();
      src_valid = '0; ready_insert = 1; tick(); ready_insert = 0; finish_pkt();
      // masked source 2 never granted; enable changes mid-packet must not disturb grant
      src_enable = 4'b1011; log_en = 1; glog.delete();
      for (int c = 0; c < 400; c++) begin
         rnd_data();
         src_valid = 4'($urandom);
         src_enable = (m_ph == 2 && $urandom_range(1)) ? 4'b1010 : 4'b1011;
         ready_insert = 1'($urandom); valid_out = 1'($urandom); ready_out = 1'($urandom); last_out = 1'($urandom);
         tick();
      end
      log_en = 0; g2 = 0;
      foreach (glog[i]) if (glog[i] == 2) g2++;
      chk("mask_src2", 32'(g2), 0);
      // fully random traffic
      for (int c = 0; c < 3000; c++) begin
         rnd_data();
         src_valid = 4'($urandom);
         src_enable = ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF;
         ready_insert = 1'($urandom); valid_out = 1'($urandom); ready_out = 1'($urandom); last_out = 1'($urandom);
         tick();
      end
      // reset in PACKET
      src_valid = 4'b0100; src_enable = '1; valid_out = 0; last_out = 0; ready_insert = 1; n = 0;
      while (m_ph != 2 && n < 50) begin
         if (m_ph == 0 || m_ph == 1) begin valid_out = 1; ready_out = 1; last_out = 1; end
         tick();
         valid_out = 0; ready_out = 0; last_out = 0;
         n++;
      end
      chk("reach_packet", 32'(busy), 1);
      src_valid = '1;
      rst_n = 0;
      #1;
      chk("arst_valid", 32'(valid_insert), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_ready", 32'(src_ready), 0);
      chk("arst_cnt", 32'(pkt_done_cnt), 0);
      chk("arst_gid", 32'(grant_id), 0);
      chk("arst_data", data_insert, 0);
      tick();
      rst_n = 1;
      #1 chk("post_rst_win", 32'(src_ready), 32'b0001);
      tick();
      src_valid = '0;
      tick();
      chk("post_rst_gid", 32'(grant_id), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
